// File: rtl/matmul_seq_engine_if.sv
// Bus bundle for matmul_seq_engine: element load port, run handshake and registered result read port.
interface matmul_seq_engine_if #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 2*DW + $clog2(N)
);
   localparam int NA = $clog2(N);

   logic          wr_en;
   logic          wr_sel;
   logic [NA-1:0] wr_row;
   logic [NA-1:0] wr_col;
   logic [DW-1:0] wr_data;
   logic          signed_mode;
   logic          start;
   logic          busy;
   logic          done;
   logic [NA-1:0] rd_row;
   logic [NA-1:0] rd_col;
   logic [AW-1:0] rd_data;

   modport master (
      output wr_en, wr_sel, wr_row, wr_col, wr_data, signed_mode, start, rd_row, rd_col,
      input  busy, done, rd_data
   );

   modport slave (
      input  wr_en, wr_sel, wr_row, wr_col, wr_data, signed_mode, start, rd_row, rd_col,
      output busy, done, rd_data
   );
endinterface

// File: rtl/matmul_seq_engine.sv
// Sequential N x N matrix multiplier: one shared MAC walks i/j/k, producing C = A x B in N^3 cycles.
module matmul_seq_engine #(
   parameter int N  = 4,
   parameter int DW = 8,
   parameter int AW = 2*DW + $clog2(N)
) (
   input  logic               clk,
   input  logic               reset,
   matmul_seq_engine_if.slave bus
);
   localparam int            NA   = $clog2(N);
   localparam int            NP   = 1 << NA;
   localparam int            PW   = 2*DW + 2;
   localparam logic [NA-1:0] LAST = NA'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   // Arrays are sized to the full index space so any wr/rd address is legal.
   logic [DW-1:0] a_mem [NP][NP];
   logic [DW-1:0] b_mem [NP][NP];
   logic [AW-1:0] c_mem [NP][NP];

   logic [NA-1:0]        i_q, j_q, k_q;
   logic                 mode_q;
   logic signed [AW-1:0] acc;
   logic signed [DW:0]   op_a_p0, op_b_p0;
   logic signed [PW-1:0] prod_full_p0;
   logic signed [AW-1:0] prod_p0;
   logic                 last_k, last_mac;

   function automatic logic signed [DW:0] ext_op(input logic [DW-1:0] v, input logic sgn);
      return signed'({sgn & v[DW-1], v});
   endfunction

   function automatic logic signed [AW-1:0] fit_acc(input logic signed [PW-1:0] p);
      logic signed [AW+PW-1:0] wide;
      wide = (AW+PW)'(p);
      return wide[AW-1:0];
   endfunction

   // MAC operand fetch and product
   always_comb begin
      op_a_p0      = ext_op(a_mem[i_q][k_q], mode_q);
      op_b_p0      = ext_op(b_mem[k_q][j_q], mode_q);
      prod_full_p0 = PW'(op_a_p0) * PW'(op_b_p0);
      prod_p0      = fit_acc(prod_full_p0);
   end

   assign last_k   = (k_q == LAST);
   assign last_mac = last_k && (j_q == LAST) && (i_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last_mac)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         RUN:     bus.busy = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // Accumulate / write-back stage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < NP; r++) begin
            for (int c = 0; c < NP; c++) begin
               a_mem[r][c] <= '0;
               b_mem[r][c] <= '0;
               c_mem[r][c] <= '0;
            end
         end
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         acc         <= '0;
         mode_q      <= 1'b0;
         bus.rd_data <= '0;
      end else begin
         bus.rd_data <= c_mem[bus.rd_row][bus.rd_col];
         if (state != RUN && bus.wr_en) begin
            if (bus.wr_sel) b_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
            else            a_mem[bus.wr_row][bus.wr_col] <= bus.wr_data;
         end
         if (state == IDLE && bus.start) begin
            mode_q <= bus.signed_mode;
            i_q    <= '0;
            j_q    <= '0;
            k_q    <= '0;
            acc    <= '0;
         end else if (state == RUN) begin
            if (last_k) begin
               c_mem[i_q][j_q] <= acc + prod_p0;
               acc             <= '0;
               k_q             <= '0;
               if (j_q == LAST) begin
                  j_q <= '0;
                  i_q <= (i_q == LAST) ? '0 : i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
            end else begin
               acc <= acc + prod_p0;
               k_q <= k_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/matmul_seq_engine.md
Name: matmul_seq_engine

Overview:
Parametrised successor to the fixed 2x2 combinational matrix multiplier: computes C = A x B for N x N matrices of DW-bit elements using a single shared multiply-accumulate datapath. A and B are loaded element-by-element over a write port. A start/busy/done handshake runs the computation, and results are read back over a registered read port. The block sits behind the user-project IO/LA glue in place of the older multiplier.

Parameters:
N, 4, matrix dimension; legal 2..8; NA = clog2(N)
DW, 8, element width in bits
AW, 2*DW+clog2(N), accumulator/result width; guaranteed overflow-free for both signed and unsigned modes

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
wr_en  input  1  load strobe for one element
wr_sel  input  1  0 = write A, 1 = write B
wr_row  input  NA  element row index
wr_col  input  NA  element column index
wr_data  input  DW  element value
signed_mode  input  1  1 = two's-complement operands/results, 0 = unsigned; sampled at start
start  input  1  request computation; level-sampled in IDLE
busy  output  1  high while computing
done  output  1  one-cycle pulse when C is complete
rd_row  input  NA  result row index
rd_col  input  NA  result column index
rd_data  output  AW  C[rd_row][rd_col], registered

Behaviour:
- Reset (async, reset=0): A, B, C arrays, accumulator, i/j/k counters, rd_data, busy, done all cleared to 0; FSM -> IDLE. Deassertion is synchronous to clk.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge -> RUN; latch signed_mode into mode_q; i=j=k=0; acc=0; busy=1 from the next cycle.
- RUN, one MAC per cycle: prod = A[i][k]*B[k][j].
  - mode_q=1: both operands sign-extended, signed product.
  - mode_q=0: zero-extended.
  - prod is extended to AW.
- Accumulation within RUN:
  - k<N-1: acc += prod; k++.
  - k=N-1: C[i][j] <= acc+prod; acc <= 0; k <= 0; advance j, wrapping to 0 and incrementing i.
  - After i=j=k=N-1 -> DONE.
- RUN lasts exactly N^3 cycles.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Latency: start sampled at edge t; busy=1 during cycles t+1..t+N^3; done=1 in cycle t+N^3+1.
- A/B writes: when wr_en=1 and FSM is IDLE or DONE, the element at [wr_row][wr_col] is written at the edge. While busy=1, wr_en is ignored and A/B stay frozen.
- start while RUN/DONE: ignored; it does not queue. start held high continuously: a new run begins from IDLE on the cycle after DONE.
- Write and start on the same IDLE edge: the write lands first and the run uses the new value, because the first MAC reads at the following edge.
- Reads: rd_data <= C[rd_row][rd_col] every cycle, giving 1-cycle latency. Reads are allowed at any time. During RUN they return old or partially updated C; already-written elements hold new values.
- C persists between runs and is overwritten element-by-element by each run.
- Reset mid-RUN: aborts immediately. A, B and C are cleared, busy=0, and no done pulse is produced.
- No truncation anywhere; AW holds the worst-case sum:
  - unsigned: N*(2^DW-1)^2
  - signed: N*2^(2DW-2)

Test Plan:
- N=2, DW=8, unsigned: load A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> busy exactly 8 cycles, done pulse on cycle 9, reads give C=[[19,22],[43,50]].
- N=4, DW=8, unsigned: all A,B=255 -> every C element = 260100 (0x3F804), no overflow within AW=18.
- N=4, signed: all A,B=-128 (0x80) -> every C = 65536. Then A[0][0]=-1, rest 0, B=identity -> C[0][0] = 0x3FFFF (-1), all others 0.
- Handshake: wr_en pulses and a second start issued during busy -> A/B unchanged and no extra run. start held high -> back-to-back runs separated by exactly one DONE cycle and one IDLE cycle.
- Reset mid-run: assert reset at cycle 20 of an N=4 run -> busy=0 and done=0 immediately. After release, reads return 0 and no done pulse appears until a new start.
- Read latency: change rd_row/rd_col each cycle in IDLE -> rd_data tracks the addressed C element exactly one cycle later.
